// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, defaults and helpers for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_t;

    localparam int   DEPTH_DEF    = 32;
    localparam int   MAX_WAIT_DEF = 4;
    localparam logic PORT_MEM     = 1'b0;
    localparam logic PORT_LDR     = 1'b1;

    // Full 32-bit compare so that large addresses never alias into the array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if;

    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        gnt0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        gnt1;

    logic        rsp_valid;
    logic        rsp_port;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall_mem;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, gnt1,
        output rsp_valid, rsp_port, rsp_rdata, rsp_err, stall_mem,
        output mem_addr, mem_wdata, mem_wr_en
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, gnt1,
        input  rsp_valid, rsp_port, rsp_rdata, rsp_err, stall_mem,
        input  mem_addr, mem_wdata, mem_wr_en
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// rtl/dmem_arb_starve_ctr.sv - counts port-1 lost cycles and decides when port 1 must be forced through
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req1,
    input  logic gnt1,
    output logic force_pri1
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    logic [3:0] wait_cnt;
    logic       lost1;

    assign lost1      = req1 & ~gnt1;
    assign force_pri1 = lost1 & (wait_cnt == WAIT_LAST);

    // Consecutive lost cycles; any grant or idle cycle restarts the count, top value holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!lost1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the MEM stage and the loader port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    arb_state_t  state;
    arb_state_t  state_next;
    logic        force_pri1;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        sel_we;
    logic        sel_ok;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic        rsp_valid_q;
    logic        rsp_port_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .req1       (bus.req1),
        .gnt1       (gnt1),
        .force_pri1 (force_pri1)
    );

    // Priority state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PRI0;
        end else begin
            state <= state_next;
        end
    end

    // PRI1 lasts exactly one cycle, so it always falls back to PRI0.
    always_comb begin
        state_next = PRI0;
        if ((state == PRI0) && force_pri1) begin
            state_next = PRI1;
        end
    end

    assign gnt0    = (state == PRI0) ? bus.req0 : (bus.req0 & ~bus.req1);
    assign gnt1    = (state == PRI1) ? bus.req1 : (bus.req1 & ~bus.req0);
    assign any_gnt = gnt0 | gnt1;

    // Select the granted port's command; an idle bus is driven to zero.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (gnt1) begin
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_we    = bus.we1;
        end else if (gnt0) begin
            sel_addr  = bus.addr0;
            sel_wdata = bus.wdata0;
            sel_we    = bus.we0;
        end
    end

    assign sel_ok = addr_in_range(sel_addr, DEPTH);

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.stall_mem = bus.req0 & ~gnt0;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_wr_en = sel_we & sel_ok;

    // Response register: one strobe per acceptance, payload held between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= PORT_MEM;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                rsp_port_q  <= gnt1 ? PORT_LDR : PORT_MEM;
                rsp_err_q   <= ~sel_ok;
                rsp_rdata_q <= (sel_ok & ~sel_we) ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_port  = rsp_port_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural reference model
module tb_dmem_arbiter;

    localparam int          DEPTH    = 32;
    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory seen by the DUT, and the model's own view of its contents.
    logic [31:0] mem_arr [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    assign bus.mem_rdata = (bus.mem_addr < DEPTH_W) ? mem_arr[bus.mem_addr[4:0]] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          lost1;
    logic        m_g0, m_g1;
    logic        e_valid, e_port, e_err;
    logic [31:0] e_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(e_valid));
        check({tag, ".rsp_port"},  32'(bus.rsp_port),  32'(e_port));
        check({tag, ".rsp_err"},   32'(bus.rsp_err),   32'(e_err));
        check({tag, ".rsp_rdata"}, bus.rsp_rdata,      e_rdata);
    endtask

    task automatic model_reset();
        lost1   = 0;
        m_g0    = 1'b0;
        m_g1    = 1'b0;
        e_valid = 1'b0;
        e_port  = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;
    endtask

    // One clock cycle, entered and left at a falling edge; inputs only change there.
    task automatic cycle();
        logic        wr, w, ok, any;
        logic [31:0] wa, wd, a, d;
        #1;
        // Port 0 wins unless port 1 has already lost MAX_WAIT cycles in a row.
        m_g1 = bus.req1 && (lost1 >= MAX_WAIT || !bus.req0);
        m_g0 = bus.req0 && !m_g1;
        any  = m_g0 || m_g1;
        a    = m_g1 ? bus.addr1  : bus.addr0;
        d    = m_g1 ? bus.wdata1 : bus.wdata0;
        w    = m_g1 ? bus.we1    : bus.we0;
        ok   = a < DEPTH_W;
        check("gnt0",      32'(bus.gnt0),      32'(m_g0));
        check("gnt1",      32'(bus.gnt1),      32'(m_g1));
        check("stall_mem", 32'(bus.stall_mem), 32'(bus.req0 && !m_g0));
        check("mem_wr_en", 32'(bus.mem_wr_en), 32'(any && w && ok));
        check("mem_addr",  bus.mem_addr,       any ? a : 32'h0);
        check("mem_wdata", bus.mem_wdata,      any ? d : 32'h0);
        wr = bus.mem_wr_en;
        wa = bus.mem_addr;
        wd = bus.mem_wdata;
        @(posedge clk);
        if (wr && wa < DEPTH_W) mem_arr[wa[4:0]] = wd;
        if (any) begin
            e_valid = 1'b1;
            e_port  = m_g1;
            e_err   = !ok;
            e_rdata = (ok && !w) ? ref_mem[a[4:0]] : 32'h0;
            if (ok && w) ref_mem[a[4:0]] = d;
        end else begin
            e_valid = 1'b0;
        end
        lost1 = (bus.req1 && !m_g1) ? lost1 + 1 : 0;
        @(negedge clk);
        check_rsp("rsp");
    endtask

    task automatic set_req(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic retire();
        if (m_g0) bus.req0 = 1'b0;
        if (m_g1) bus.req1 = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            8:       return 32'd32;
            9:       return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        int first;
        for (int i = 0; i < DEPTH; i++) begin
            mem_arr[i] = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_rsp("reset");
        reset = 1'b1;

        // Single read from port 0.
        set_req(0, 1'b0, 32'd3, 32'h0);
        cycle();
        check("t1.rdata", bus.rsp_rdata, 32'hA5A5_0003);
        retire();

        // Write then read the same word on consecutive grants.
        set_req(0, 1'b1, 32'd5, 32'h1234);
        cycle();
        retire();
        set_req(0, 1'b0, 32'd5, 32'h0);
        cycle();
        check("t2.rdata", bus.rsp_rdata, 32'h1234);
        retire();

        // Both ports saturated: port 1 forced through after MAX_WAIT lost cycles.
        first = -1;
        set_req(1, 1'b0, 32'd9, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (!bus.req0) set_req(0, 1'b0, 32'(i), 32'h0);
            cycle();
            if (m_g1 && first < 0) first = i;
            retire();
        end
        check("t3.first_gnt1", 32'(first), 32'(MAX_WAIT));

        // Out-of-range read from port 1.
        set_req(1, 1'b0, 32'd32, 32'h0);
        cycle();
        check("t4.err", 32'(bus.rsp_err), 32'd1);
        retire();

        // Reset right after a grant, with port 1 still waiting.
        set_req(1, 1'b0, 32'd7, 32'h0);
        set_req(0, 1'b0, 32'd1, 32'h0);
        cycle();
        retire();
        reset = 1'b0;
        #1;
        check("t5.rsp_valid_in_reset", 32'(bus.rsp_valid), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle();
        check("t5.rsp_port", 32'(bus.rsp_port), 32'd1);
        retire();
        cycle();

        // Back-to-back reads with no gaps.
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b0, 32'(i), 32'h0);
            cycle();
            check("t6.rsp_valid", 32'(bus.rsp_valid), 32'd1);
            retire();
        end

        // Randomized traffic from both ports.
        for (int n = 0; n < 3000; n++) begin
            if (!bus.req0 && $urandom_range(0, 99) < 65)
                set_req(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (!bus.req1 && $urandom_range(0, 99) < 50)
                set_req(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            cycle();
            retire();
        end
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
